isqrt_seq: RTL and testbench

//  Sequential restoring integer square root of an unsigned WIDTH-bit radicand.

---
 rtl/isqrt_seq.sv | 153 +++++++++++++++
 tb/tb_isqrt_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root: UNROLL radicand bit pairs per clock,
// one operation in flight, valid/ready handshake on both sides.
module isqrt_seq #(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic [WIDTH-1:0]     RADICAND,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [WIDTH/2-1:0]   ROOT,
   output logic [WIDTH/2:0]     REM,
   output logic                 BUSY
);

   localparam int HW = WIDTH / 2;
   localparam int RW = HW + 2;
   localparam int CW = $clog2(HW + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  rad_q, rad_d;
   logic [HW-1:0]     acc_root_q, acc_root_d;
   logic [RW-1:0]     acc_rem_q, acc_rem_d;
   logic [CW-1:0]     count_q, count_d;
   logic [HW-1:0]     root_q, root_d;
   logic [HW:0]       rem_q, rem_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;

   logic [WIDTH-1:0]  step_rad;
   logic [HW-1:0]     step_root;
   logic [RW-1:0]     step_rem;
   logic [RW-1:0]     trial_rem;
   logic [RW-1:0]     trial_sub;
   logic [CW-1:0]     count_inc;

   // Digit recurrence: UNROLL restoring steps chained combinationally, MSB pair first.
   always_comb begin
      step_rad  = rad_q;
      step_root = acc_root_q;
      step_rem  = acc_rem_q;
      trial_rem = {RW{1'b0}};
      trial_sub = {RW{1'b0}};
      for (int i = 0; i < UNROLL; i++) begin
         trial_rem = {step_rem[RW-3:0], step_rad[WIDTH-1 -: 2]};
         trial_sub = {step_root, 2'b01};
         if (trial_rem >= trial_sub) begin
            step_rem  = trial_rem - trial_sub;
            step_root = {step_root[HW-2:0], 1'b1};
         end else begin
            step_rem  = trial_rem;
            step_root = {step_root[HW-2:0], 1'b0};
         end
         step_rad = {step_rad[WIDTH-3:0], 2'b00};
      end
      count_inc = count_q + CW'(UNROLL);
   end

   // Next-state and next-output computation for the IDLE -> CALC -> DONE sequence.
   always_comb begin
      state_d    = state_q;
      rad_d      = rad_q;
      acc_root_d = acc_root_q;
      acc_rem_d  = acc_rem_q;
      count_d    = count_q;
      root_d     = root_q;
      rem_d      = rem_q;
      case (state_q)
         S_IDLE: begin
            if (IN_VALID && in_ready_q) begin
               state_d    = S_CALC;
               rad_d      = RADICAND;
               acc_root_d = {HW{1'b0}};
               acc_rem_d  = {RW{1'b0}};
               count_d    = {CW{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            rad_d      = step_rad;
            acc_root_d = step_root;
            acc_rem_d  = step_rem;
            count_d    = count_inc;
            // Result registers only move on the final step so they hold the previous answer meanwhile.
            if (count_inc == CW'(HW)) begin
               state_d = S_DONE;
               root_d  = step_root;
               rem_d   = step_rem[HW:0];
            end else begin
               state_d = S_CALC;
            end
         end
         S_DONE: begin
            if (OUT_READY) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   // State and registered outputs; synchronous reset overrides any handshake.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         rad_q       <= {WIDTH{1'b0}};
         acc_root_q  <= {HW{1'b0}};
         acc_rem_q   <= {RW{1'b0}};
         count_q     <= {CW{1'b0}};
         root_q      <= {HW{1'b0}};
         rem_q       <= {(HW+1){1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rad_q       <= rad_d;
         acc_root_q  <= acc_root_d;
         acc_rem_q   <= acc_rem_d;
         count_q     <= count_d;
         root_q      <= root_d;
         rem_q       <= rem_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = out_valid_q;
   assign ROOT      = root_q;
   assign REM       = rem_q;
   assign BUSY      = busy_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq: scoreboard of expected results built from an
// independent binary-search square root, plus UNROLL=4 and WIDTH=8 instances.
module tb_isqrt_seq;

   typedef struct packed {
      logic [31:0] rad;
      logic [15:0] root;
      logic [16:0] rem;
   } exp_t;

   logic CLK;
   logic RESET;

   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [31:0] radicand;
   logic [15:0] root;
   logic [16:0] rem;

   logic        in_valid4, in_ready4, out_valid4, busy4;
   logic [31:0] radicand4;
   logic [15:0] root4;
   logic [16:0] rem4;

   logic        in_valid8, in_ready8, out_valid8, busy8;
   logic [7:0]  radicand8;
   logic [3:0]  root8;
   logic [4:0]  rem8;

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t sb_q[$];

   isqrt_seq #(.WIDTH(32), .UNROLL(1)) dut (
      .CLK(CLK), .RESET(RESET), .IN_VALID(in_valid), .IN_READY(in_ready),
      .RADICAND(radicand), .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .ROOT(root), .REM(rem), .BUSY(busy));

   isqrt_seq #(.WIDTH(32), .UNROLL(4)) u4 (
      .CLK(CLK), .RESET(RESET), .IN_VALID(in_valid4), .IN_READY(in_ready4),
      .RADICAND(radicand4), .OUT_VALID(out_valid4), .OUT_READY(1'b1),
      .ROOT(root4), .REM(rem4), .BUSY(busy4));

   isqrt_seq #(.WIDTH(8), .UNROLL(2)) u8 (
      .CLK(CLK), .RESET(RESET), .IN_VALID(in_valid8), .IN_READY(in_ready8),
      .RADICAND(radicand8), .OUT_VALID(out_valid8), .OUT_READY(1'b1),
      .ROOT(root8), .REM(rem8), .BUSY(busy8));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic exp_t model(input logic [31:0] x);
      exp_t   m;
      longint lo, hi, mid;
      lo = 0;
      hi = 65536;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= longint'(x)) lo = mid;
         else hi = mid;
      end
      m.rad  = x;
      m.root = 16'(lo);
      m.rem  = 17'(longint'(x) - lo * lo);
      return m;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [31:0] x);
      int k;
      k = 0;
      while (!in_ready && k < 100) begin
         tick();
         k++;
      end
      if (!in_ready) begin
         n_cmp++; n_fail++;
         $display("FAIL send_wait: in_ready got %b required 1", in_ready);
      end
      in_valid = 1'b1;
      radicand = x;
      tick();
      in_valid = 1'b0;
      radicand = $urandom;
      sb_q.push_back(model(x));
   endtask

   task automatic wait_valid(input bit rnd, output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b0;
      if (!out_valid) begin
         n_cmp++; n_fail++;
         $display("FAIL wait_valid: out_valid got %b required 1 within 100 cycles", out_valid);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) tick();
      RESET = 1'b0;
      n_cmp += 5;
      if (in_ready  !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      if (busy      !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
      if (root      !== 16'h0) begin n_fail++; $display("FAIL reset_root: got %h required 0", root); end
      if (rem       !== 17'h0) begin n_fail++; $display("FAIL reset_rem: got %h required 0", rem); end
   endtask

   task automatic test_basic(input logic [31:0] x);
      exp_t e;
      int   lat;
      send(x);
      wait_valid(1'b0, lat);
      e = sb_q.pop_front();
      n_cmp += 5;
      if (lat  !== 16)     begin n_fail++; $display("FAIL basic_latency x=%0d: got %0d required 16", x, lat); end
      if (root !== e.root) begin n_fail++; $display("FAIL basic_root x=%0d: got %0d required %0d", x, root, e.root); end
      if (rem  !== e.rem)  begin n_fail++; $display("FAIL basic_rem x=%0d: got %0d required %0d", x, rem, e.rem); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop_valid: got %b required 0", out_valid); end
      if (in_ready  !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b required 1", in_ready); end
   endtask

   task automatic test_hold();
      exp_t        e;
      int          lat;
      logic [15:0] snap_root;
      logic [16:0] snap_rem;
      send(32'd123456789);
      wait_valid(1'b0, lat);
      e = sb_q.pop_front();
      snap_root = root;
      snap_rem  = rem;
      in_valid  = 1'b1;
      radicand  = 32'd7;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp += 5;
         if (out_valid !== 1'b1)      begin n_fail++; $display("FAIL hold_valid c%0d: got %b required 1", i, out_valid); end
         if (root      !== snap_root) begin n_fail++; $display("FAIL hold_root c%0d: got %h required %h", i, root, snap_root); end
         if (rem       !== snap_rem)  begin n_fail++; $display("FAIL hold_rem c%0d: got %h required %h", i, rem, snap_rem); end
         if (in_ready  !== 1'b0)      begin n_fail++; $display("FAIL hold_in_ready c%0d: got %b required 0", i, in_ready); end
         if (busy      !== 1'b1)      begin n_fail++; $display("FAIL hold_busy c%0d: got %b required 1", i, busy); end
      end
      in_valid = 1'b0;
      n_cmp += 5;
      if (root !== e.root) begin n_fail++; $display("FAIL hold_result_root: got %0d required %0d", root, e.root); end
      if (rem  !== e.rem)  begin n_fail++; $display("FAIL hold_result_rem: got %0d required %0d", rem, e.rem); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid: got %b required 0", out_valid); end
      tick();
      if (busy     !== 1'b0) begin n_fail++; $display("FAIL hold_not_accepted_busy: got %b required 0", busy); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_not_accepted_ready: got %b required 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   lat;
      send(32'd99999);
      void'(sb_q.pop_back());
      repeat (6) tick();
      RESET     = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      RESET     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_cmp += 5;
      if (in_ready  !== 1'b1)  begin n_fail++; $display("FAIL abort_in_ready: got %b required 1", in_ready); end
      if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL abort_out_valid: got %b required 0", out_valid); end
      if (busy      !== 1'b0)  begin n_fail++; $display("FAIL abort_busy: got %b required 0", busy); end
      if (root      !== 16'h0) begin n_fail++; $display("FAIL abort_root: got %h required 0", root); end
      if (rem       !== 17'h0) begin n_fail++; $display("FAIL abort_rem: got %h required 0", rem); end
      repeat (20) tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_stale_valid: got %b required 0", out_valid); end
      send(32'd144);
      wait_valid(1'b0, lat);
      e = sb_q.pop_front();
      n_cmp += 2;
      if (root !== e.root) begin n_fail++; $display("FAIL abort_next_root: got %0d required %0d", root, e.root); end
      if (rem  !== e.rem)  begin n_fail++; $display("FAIL abort_next_rem: got %0d required %0d", rem, e.rem); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_unroll();
      logic [31:0] v4[2];
      logic [7:0]  v8[3];
      exp_t        e;
      int          lat;
      v4 = '{32'd1000000, 32'hFFFFFFFF};
      v8 = '{8'd255, 8'd200, 8'd0};
      foreach (v4[i]) begin
         e = model(v4[i]);
         in_valid4 = 1'b1;
         radicand4 = v4[i];
         tick();
         in_valid4 = 1'b0;
         lat = 0;
         while (!out_valid4 && lat < 50) begin tick(); lat++; end
         n_cmp += 3;
         if (lat   !== 4)      begin n_fail++; $display("FAIL u4_latency x=%0d: got %0d required 4", v4[i], lat); end
         if (root4 !== e.root) begin n_fail++; $display("FAIL u4_root x=%0d: got %0d required %0d", v4[i], root4, e.root); end
         if (rem4  !== e.rem)  begin n_fail++; $display("FAIL u4_rem x=%0d: got %0d required %0d", v4[i], rem4, e.rem); end
         tick();
      end
      foreach (v8[i]) begin
         e = model({24'd0, v8[i]});
         in_valid8 = 1'b1;
         radicand8 = v8[i];
         tick();
         in_valid8 = 1'b0;
         lat = 0;
         while (!out_valid8 && lat < 50) begin tick(); lat++; end
         n_cmp += 3;
         if (lat   !== 2)            begin n_fail++; $display("FAIL u8_latency x=%0d: got %0d required 2", v8[i], lat); end
         if (root8 !== e.root[3:0])  begin n_fail++; $display("FAIL u8_root x=%0d: got %0d required %0d", v8[i], root8, e.root); end
         if (rem8  !== e.rem[4:0])   begin n_fail++; $display("FAIL u8_rem x=%0d: got %0d required %0d", v8[i], rem8, e.rem); end
         tick();
      end
   endtask

   task automatic test_random(input int n);
      exp_t        e;
      int          lat;
      logic [31:0] x;
      for (int i = 0; i < n; i++) begin
         x = $urandom;
         if (i % 97 == 0) x = 32'hFFFFFFFF;
         if (i % 89 == 0) x = 32'h0;
         if (i % 13 == 0) x = x >> $urandom_range(0, 31);
         send(x);
         wait_valid(1'b1, lat);
         e = sb_q.pop_front();
         n_cmp += 5;
         if (lat  !== 16)     begin n_fail++; $display("FAIL rnd_latency x=%h: got %0d required 16", x, lat); end
         if (root !== e.root) begin n_fail++; $display("FAIL rnd_root x=%h: got %0d required %0d", x, root, e.root); end
         if (rem  !== e.rem)  begin n_fail++; $display("FAIL rnd_rem x=%h: got %0d required %0d", x, rem, e.rem); end
         if (longint'(root) * longint'(root) + longint'(rem) != longint'(e.rad) || longint'(rem) > 2 * longint'(root)) begin
            n_fail++;
            $display("FAIL rnd_invariant x=%h: got root=%0d rem=%0d", e.rad, root, rem);
         end
         repeat ($urandom_range(0, 3)) tick();
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_release x=%h: got %b required 0", x, out_valid); end
      end
   endtask

   initial begin
      RESET     = 1'b1;
      in_valid  = 1'b0;
      radicand  = 32'h0;
      out_ready = 1'b0;
      in_valid4 = 1'b0;
      radicand4 = 32'h0;
      in_valid8 = 1'b0;
      radicand8 = 8'h0;
      test_reset();
      test_basic(32'd0);
      test_basic(32'd17);
      test_basic(32'd1000000);
      test_basic(32'hFFFFFFFF);
      test_hold();
      test_reset_mid();
      test_unroll();
      test_random(1500);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
